// File: rtl/program_counter.sv
// Hack-style program counter with clear/return/call/load/increment/hold priority.
// Define PC_STACK_EN to build the hardware return-address stack and its sp/ovf/unf status.
module program_counter #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       load,
   input  logic                       inc,
   input  logic                       call,
   input  logic                       ret,
   input  logic [WIDTH-1:0]           in,
   output logic [WIDTH-1:0]           out,
   output logic [$clog2(DEPTH+1)-1:0] sp,
   output logic                       ovf,
   output logic                       unf
);

   localparam int SPW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] out_next;

`ifdef PC_STACK_EN

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] stack [DEPTH];
   logic [SPW-1:0]   sp_next;
   logic             ovf_next;
   logic             unf_next;
   logic             push;
   logic             full;
   logic             empty;

   assign full  = (sp == SPW'(DEPTH));
   assign empty = (sp == '0);

   // A full-stack call still jumps; only the saved return address is lost.
   always_comb begin
      out_next = out;
      sp_next  = sp;
      ovf_next = ovf;
      unf_next = unf;
      push     = 1'b0;
      if (clr) begin
         out_next = RESET_VEC;
         sp_next  = '0;
         ovf_next = 1'b0;
         unf_next = 1'b0;
      end else if (ret) begin
         if (!empty) begin
            out_next = stack[AW'(sp - SPW'(1))];
            sp_next  = sp - SPW'(1);
         end else begin
            unf_next = 1'b1;
         end
      end else if (call) begin
         out_next = in;
         if (!full) begin
            push    = 1'b1;
            sp_next = sp + SPW'(1);
         end else begin
            ovf_next = 1'b1;
         end
      end else if (load) begin
         out_next = in;
      end else if (inc) begin
         out_next = out + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= RESET_VEC;
         sp  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         out <= out_next;
         sp  <= sp_next;
         ovf <= ovf_next;
         unf <= unf_next;
      end
   end

   // Stack contents are don't-care after reset, so the storage carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[AW'(sp)] <= out + WIDTH'(1);
      end
   end

`else

   // Without the stack, ret degrades to hold and call to a plain jump.
   always_comb begin
      out_next = out;
      if (clr) begin
         out_next = RESET_VEC;
      end else if (ret) begin
         out_next = out;
      end else if (call || load) begin
         out_next = in;
      end else if (inc) begin
         out_next = out + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= RESET_VEC;
      end else begin
         out <= out_next;
      end
   end

   assign sp  = '0;
   assign ovf = 1'b0;
   assign unf = 1'b0;

`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter; follows PC_STACK_EN to pick the matching reference model.
module tb_program_counter;

   localparam int               WIDTH     = 16;
   localparam int               DEPTH     = 8;
   localparam int               SPW       = $clog2(DEPTH + 1);
   localparam logic [WIDTH-1:0] RESET_VEC = 16'h0000;

   typedef struct packed {
      logic [WIDTH-1:0] out;
      logic [SPW-1:0]   sp;
      logic             ovf;
      logic             unf;
   } snap_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             clr = 1'b0;
   logic             load = 1'b0;
   logic             inc = 1'b0;
   logic             call = 1'b0;
   logic             ret = 1'b0;
   logic [WIDTH-1:0] pc_in = '0;
   logic [WIDTH-1:0] out;
   logic [SPW-1:0]   sp;
   logic             ovf;
   logic             unf;

   int n_run  = 0;
   int n_fail = 0;

   snap_t sb [$];

   logic [WIDTH-1:0] m_out = RESET_VEC;
   logic [WIDTH-1:0] m_stk [$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc),
      .call(call), .ret(ret), .in(pc_in), .out(out), .sp(sp), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   function automatic snap_t observed();
      return '{out: out, sp: sp, ovf: ovf, unf: unf};
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("out=%h sp=%0d ovf=%b unf=%b", s.out, s.sp, s.ovf, s.unf);
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s.out = m_out;
`ifdef PC_STACK_EN
      s.sp  = SPW'(m_stk.size());
`else
      s.sp  = '0;
`endif
      s.ovf = m_ovf;
      s.unf = m_unf;
      return s;
   endfunction

   function automatic void model_reset();
      m_out = RESET_VEC;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endfunction

   function automatic void model_step(input logic c_clr, c_ret, c_call, c_load, c_inc,
                                      input logic [WIDTH-1:0] d);
      if (c_clr) begin
         model_reset();
      end else if (c_ret) begin
`ifdef PC_STACK_EN
         if (m_stk.size() > 0) m_out = m_stk.pop_back();
         else                  m_unf = 1'b1;
`endif
      end else if (c_call) begin
`ifdef PC_STACK_EN
         if (m_stk.size() < DEPTH) m_stk.push_back(m_out + 16'd1);
         else                      m_ovf = 1'b1;
`endif
         m_out = d;
      end else if (c_load) begin
         m_out = d;
      end else if (c_inc) begin
         m_out = m_out + 16'd1;
      end
   endfunction

   // Drive one cycle of strobes, queue the model's prediction, sample 1ns after the edge.
   task automatic applyStimulus(input logic c_clr, c_ret, c_call, c_load, c_inc,
                                input logic [WIDTH-1:0] d);
      @(negedge clk);
      clr = c_clr; ret = c_ret; call = c_call; load = c_load; inc = c_inc; pc_in = d;
      model_step(c_clr, c_ret, c_call, c_load, c_inc, d);
      sb.push_back(model_snap());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      snap_t exp;
      @(negedge clk);
      pc_in = 16'd1234; load = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_run++;
      if (observed() !== model_snap()) begin
         n_fail++;
         $display("[TB] FAIL async_reset got %s want %s", fmt(observed()), fmt(model_snap()));
      end
      @(posedge clk);
      #1;
      n_run++;
      if (observed() !== model_snap()) begin
         n_fail++;
         $display("[TB] FAIL reset_held got %s want %s", fmt(observed()), fmt(model_snap()));
      end
      @(negedge clk);
      rst_n = 1'b1; load = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
         exp = sb.pop_front();
         n_run++;
         if (observed() !== exp || out !== WIDTH'(i)) begin
            n_fail++;
            $display("[TB] FAIL inc_after_reset[%0d] got %s want %s", i, fmt(observed()), fmt(exp));
         end
      end
   endtask

   task automatic test_wrap();
      snap_t exp;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE);
      sb.delete();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
         exp = sb.pop_front();
         n_run++;
         if (observed() !== exp) begin
            n_fail++;
            $display("[TB] FAIL wrap[%0d] got %s want %s", i, fmt(observed()), fmt(exp));
         end
      end
      n_run++;
      if (out !== 16'h0000 || ovf !== 1'b0 || unf !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL wrap_zero got out=%h ovf=%b unf=%b want out=0000 ovf=0 unf=0", out, ovf, unf);
      end
   endtask

   task automatic test_load_priority();
      snap_t exp;
      logic [WIDTH-1:0] neg = -16'sd32123;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, neg);
      exp = sb.pop_front();
      n_run++;
      if (observed() !== exp || out !== 16'h8285) begin
         n_fail++;
         $display("[TB] FAIL load_over_inc got %s want %s", fmt(observed()), fmt(exp));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111);
      exp = sb.pop_front();
      n_run++;
      if (observed() !== exp || out !== 16'h8285) begin
         n_fail++;
         $display("[TB] FAIL hold got %s want %s", fmt(observed()), fmt(exp));
      end
   endtask

   task automatic test_call_ret();
      snap_t exp;
      logic [WIDTH-1:0] tgt [5];
      logic             is_ret [5];
      tgt    = '{16'd100, 16'd200, 16'd0, 16'd0, 16'd0};
      is_ret = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10);
      sb.delete();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, is_ret[i], !is_ret[i], 1'b0, 1'b0, tgt[i]);
         exp = sb.pop_front();
         n_run++;
         if (observed() !== exp) begin
            n_fail++;
            $display("[TB] FAIL call_ret[%0d] got %s want %s", i, fmt(observed()), fmt(exp));
         end
      end
   endtask

   task automatic test_overflow();
      snap_t exp;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      sb.delete();
      for (int i = 0; i <= DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WIDTH'(1000 + i));
         exp = sb.pop_front();
         n_run++;
         if (observed() !== exp) begin
            n_fail++;
            $display("[TB] FAIL overflow_call[%0d] got %s want %s", i, fmt(observed()), fmt(exp));
         end
      end
      n_run++;
      if (out !== WIDTH'(1000 + DEPTH)) begin
         n_fail++;
         $display("[TB] FAIL overflow_last_target got out=%h want %h", out, WIDTH'(1000 + DEPTH));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      exp = sb.pop_front();
      n_run++;
      if (observed() !== exp || out !== RESET_VEC || ovf !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL clr_after_overflow got %s want %s", fmt(observed()), fmt(exp));
      end
   endtask

   task automatic test_mid_reset();
      snap_t exp;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd500);
      sb.delete();
      @(negedge clk);
      call = 1'b1; pc_in = 16'd77;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_run++;
      if (observed() !== model_snap() || out !== RESET_VEC) begin
         n_fail++;
         $display("[TB] FAIL mid_op_reset got %s want %s", fmt(observed()), fmt(model_snap()));
      end
      @(negedge clk);
      rst_n = 1'b1; call = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321);
      sb.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5555);
      exp = sb.pop_front();
      n_run++;
      if (observed() !== exp || out !== RESET_VEC) begin
         n_fail++;
         $display("[TB] FAIL clr_ret_load got %s want %s", fmt(observed()), fmt(exp));
      end
   endtask

   task automatic test_back_to_back();
      snap_t exp;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                       ($urandom_range(0, 1) == 0), WIDTH'($urandom));
         exp = sb.pop_front();
         n_run++;
         if (observed() !== exp) begin
            n_fail++;
            $display("[TB] FAIL random[%0d] got %s want %s", i, fmt(observed()), fmt(exp));
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_load_priority();
      test_call_ret();
      test_overflow();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
